descriptor_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one downstream descriptor channel (46-bit descriptor, wr/ack handshake) between four descriptor sources in the forwarding/lookup path. It sits between the per-port descriptor producers and the descriptor delay stage feeding the buffer manager. It grants one source at a time, presents that source's descriptor downstream, and holds it until the downstream ack. An optional gap of idle cycles follows each transfer.

---
 rtl/descriptor_rr_arbiter_pkg.sv | 14 +
 rtl/descriptor_rr_select.sv | 30 +++
 rtl/descriptor_rr_arbiter.sv | 115 +++++++++++
 tb/tb_descriptor_rr_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/descriptor_rr_arbiter_pkg.sv
// Shared constants and FSM state encoding for the descriptor round-robin arbiter.
package descriptor_rr_arbiter_pkg;

  localparam int unsigned DescW  = 46;
  localparam int unsigned NumSrc = 4;
  localparam int unsigned PtrW   = 2;

  typedef enum logic [1:0] {
    IDLE_S = 2'd0,
    SEND_S = 2'd1,
    GAP_S  = 2'd2
  } state_t;

endpackage

// File: rtl/descriptor_rr_select.sv
// Combinational round-robin pick: first requester after the last-granted source.
module descriptor_rr_select
  import descriptor_rr_arbiter_pkg::*;
(
  input  logic [NumSrc-1:0] iv_req,
  input  logic [PtrW-1:0]   iv_last,
  output logic [NumSrc-1:0] ov_grant,
  output logic [PtrW-1:0]   ov_grant_idx
);

  logic            w_found;
  logic [PtrW-1:0] w_idx;

  // Scan last+1 .. last+4 (mod 4); the final step wraps back to the last grantee.
  always_comb begin
    ov_grant     = '0;
    ov_grant_idx = '0;
    w_found      = 1'b0;
    w_idx        = '0;
    for (int unsigned i = 1; i <= NumSrc; i++) begin
      w_idx = PtrW'(iv_last + PtrW'(i));
      if (!w_found && iv_req[w_idx]) begin
        w_found          = 1'b1;
        ov_grant[w_idx]  = 1'b1;
        ov_grant_idx     = w_idx;
      end
    end
  end

endmodule

// File: rtl/descriptor_rr_arbiter.sv
// Four-source round-robin arbiter onto one descriptor channel with wr/ack handshake
// and an optional idle gap after each downstream accept.
module descriptor_rr_arbiter
  import descriptor_rr_arbiter_pkg::*;
#(
  parameter logic [3:0] gap_cycle = 4'd0
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [NumSrc*DescW-1:0] iv_descriptor,
  input  logic [NumSrc-1:0]       iv_descriptor_wr,
  output logic [NumSrc-1:0]       ov_descriptor_ack,
  output logic [DescW-1:0]        ov_descriptor,
  output logic                    o_descriptor_wr,
  input  logic                    i_descriptor_ack
);

  state_t            r_state, w_state_next;
  logic [PtrW-1:0]   r_last, w_last_next;
  logic [3:0]        r_gap_cnt, w_gap_next;
  logic [DescW-1:0]  r_desc, w_desc_next;
  logic              r_wr, w_wr_next;
  logic [NumSrc-1:0] r_ack, w_ack_next;

  logic [NumSrc-1:0] w_grant;
  logic [PtrW-1:0]   w_grant_idx;
  logic [DescW-1:0]  w_sel_desc;

  descriptor_rr_select u_select (
    .iv_req       (iv_descriptor_wr),
    .iv_last      (r_last),
    .ov_grant     (w_grant),
    .ov_grant_idx (w_grant_idx)
  );

  // Descriptor mux driven by the one-hot grant.
  always_comb begin
    w_sel_desc = '0;
    for (int k = 0; k < NumSrc; k++) begin
      if (w_grant[k]) w_sel_desc = iv_descriptor[k*DescW +: DescW];
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    w_state_next = r_state;
    w_last_next  = r_last;
    w_gap_next   = r_gap_cnt;
    w_desc_next  = r_desc;
    w_wr_next    = r_wr;
    w_ack_next   = '0;
    case (r_state)
      IDLE_S: begin
        if (|iv_descriptor_wr) begin
          w_desc_next  = w_sel_desc;
          w_wr_next    = 1'b1;
          w_ack_next   = w_grant;
          w_last_next  = w_grant_idx;
          w_state_next = SEND_S;
        end else begin
          w_desc_next = '0;
          w_wr_next   = 1'b0;
        end
      end
      SEND_S: begin
        // Source requests are ignored here; the granted source is already served.
        if (i_descriptor_ack) begin
          w_desc_next  = '0;
          w_wr_next    = 1'b0;
          w_state_next = (gap_cycle != 4'd0) ? GAP_S : IDLE_S;
        end
      end
      GAP_S: begin
        w_desc_next = '0;
        w_wr_next   = 1'b0;
        if (r_gap_cnt == gap_cycle - 4'd1) begin
          w_gap_next   = '0;
          w_state_next = IDLE_S;
        end else begin
          w_gap_next = r_gap_cnt + 4'd1;
        end
      end
      default: begin
        w_desc_next  = '0;
        w_wr_next    = 1'b0;
        w_gap_next   = '0;
        w_state_next = IDLE_S;
      end
    endcase
  end

  // State and output registers; pointer resets to 3 so port 0 wins first.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= IDLE_S;
      r_last    <= PtrW'(NumSrc - 1);
      r_gap_cnt <= '0;
      r_desc    <= '0;
      r_wr      <= 1'b0;
      r_ack     <= '0;
    end else begin
      r_state   <= w_state_next;
      r_last    <= w_last_next;
      r_gap_cnt <= w_gap_next;
      r_desc    <= w_desc_next;
      r_wr      <= w_wr_next;
      r_ack     <= w_ack_next;
    end
  end

  assign ov_descriptor     = r_desc;
  assign o_descriptor_wr   = r_wr;
  assign ov_descriptor_ack = r_ack;

endmodule

// File: tb/tb_descriptor_rr_arbiter.sv
// Directed bench for descriptor_rr_arbiter: instance 0 has no gap, instance 1 a 3-cycle gap.
module tb_descriptor_rr_arbiter;

  typedef struct packed {
    int          d;
    int          port;
    logic [45:0] desc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [183:0] iv_desc [2];
  logic [3:0]   iv_wr   [2];
  logic [3:0]   ov_ack  [2];
  logic [45:0]  ov_desc [2];
  logic         o_wr    [2];
  logic         i_ack   [2];

  exp_t sb [$];
  int   gq [$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   n_grant [2];
  int   grant_cyc [2];
  int   ack_cyc [2];
  int   gap_obs [2];
  bit   ds_en [2];
  int   hold [2];
  bit   spurious [2];
  bit   rearm [2];
  bit [3:0] rearm_pend [2];
  int   seq [2][4];

  always #5 clk = ~clk;

  descriptor_rr_arbiter #(.gap_cycle(4'd0)) u_dut0 (
    .i_clk             (clk),
    .i_rst             (rst),
    .iv_descriptor     (iv_desc[0]),
    .iv_descriptor_wr  (iv_wr[0]),
    .ov_descriptor_ack (ov_ack[0]),
    .ov_descriptor     (ov_desc[0]),
    .o_descriptor_wr   (o_wr[0]),
    .i_descriptor_ack  (i_ack[0])
  );

  descriptor_rr_arbiter #(.gap_cycle(4'd3)) u_dut1 (
    .i_clk             (clk),
    .i_rst             (rst),
    .iv_descriptor     (iv_desc[1]),
    .iv_descriptor_wr  (iv_wr[1]),
    .ov_descriptor_ack (ov_ack[1]),
    .ov_descriptor     (ov_desc[1]),
    .o_descriptor_wr   (o_wr[1]),
    .i_descriptor_ack  (i_ack[1])
  );

  function automatic logic [45:0] make_desc(input int k, input int n);
    return {4'hA, k[1:0], n[7:0], 32'(32'h5A5A_0000 + k)};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int d, input int port, input logic [45:0] desc);
    exp_t e;
    e.d = d;
    e.port = port;
    e.desc = desc;
    sb.push_back(e);
  endtask

  task automatic set_src(input int d, input int k, input logic [45:0] desc);
    iv_desc[d][46*k +: 46] = desc;
    iv_wr[d][k] = 1'b1;
  endtask

  // One clock: scoreboard grants, model registered sources and the downstream sink.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    cyc++;
    #1;
    for (int d = 0; d < 2; d++) begin
      if (ov_ack[d] != 4'b0) begin
        n_grant[d]++;
        grant_cyc[d] = cyc;
        gap_obs[d] = cyc - ack_cyc[d];
        if (d == 0) gq.push_back(cyc);
        if (sb.size() == 0) begin
          check("unexpected_grant", 64'(ov_ack[d]), 64'd0);
        end else begin
          e = sb.pop_front();
          check("grant_dut", 64'(d), 64'(e.d));
          check("grant_ack", 64'(ov_ack[d]), 64'(4'b0001 << e.port));
          check("grant_desc", 64'(ov_desc[d]), 64'(e.desc));
          check("grant_wr", 64'(o_wr[d]), 64'd1);
        end
      end
      for (int k = 0; k < 4; k++) begin
        if (rearm_pend[d][k]) begin
          rearm_pend[d][k] = 1'b0;
          set_src(d, k, make_desc(k, seq[d][k]));
        end
        if (ov_ack[d][k]) begin
          iv_wr[d][k] = 1'b0;
          seq[d][k]++;
          if (rearm[d]) rearm_pend[d][k] = 1'b1;
        end
      end
      if (spurious[d]) begin
        i_ack[d] = 1'b1;
      end else if (o_wr[d] && ds_en[d]) begin
        if (hold[d] > 0) begin
          hold[d]--;
          i_ack[d] = 1'b0;
        end else begin
          i_ack[d] = 1'b1;
          ack_cyc[d] = cyc + 1;
        end
      end else begin
        i_ack[d] = 1'b0;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int start, tgt, rel, base;
    bit stable;
    logic [45:0] dx, dy;

    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      iv_desc[d] = '0;
      iv_wr[d] = '0;
      i_ack[d] = 1'b0;
      n_grant[d] = 0;
      grant_cyc[d] = 0;
      ack_cyc[d] = 0;
      gap_obs[d] = 0;
      ds_en[d] = 1'b1;
      hold[d] = 0;
      spurious[d] = 1'b0;
      rearm[d] = 1'b0;
      rearm_pend[d] = '0;
      for (int k = 0; k < 4; k++) seq[d][k] = 0;
    end
    tick();
    tick();
    for (int d = 0; d < 2; d++) begin
      check("reset_wr", 64'(o_wr[d]), 64'd0);
      check("reset_ack", 64'(ov_ack[d]), 64'd0);
      check("reset_desc", 64'(ov_desc[d]), 64'd0);
    end
    rst = 1'b0;
    tick();

    // Single request from source 2.
    start = cyc;
    set_src(0, 2, 46'h155);
    push(0, 2, 46'h155);
    tick();
    check("t1_grant_cyc", 64'(grant_cyc[0]), 64'(start + 1));
    check("t1_grant_count", 64'(n_grant[0]), 64'd1);
    tick();
    check("t1_wr_after_ack", 64'(o_wr[0]), 64'd0);
    check("t1_desc_after_ack", 64'(ov_desc[0]), 64'd0);
    tick();

    // All sources request continuously; pointer is 2 so the order starts at 3.
    gq.delete();
    rearm[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      seq[0][k] = 0;
      set_src(0, k, make_desc(k, 0));
    end
    for (int i = 0; i < 8; i++) push(0, (3 + i) % 4, make_desc((3 + i) % 4, i / 4));
    tgt = n_grant[0] + 8;
    for (int i = 0; i < 40 && n_grant[0] < tgt; i++) tick();
    check("rr_grant_count", 64'(n_grant[0]), 64'(tgt));
    rearm[0] = 1'b0;
    rearm_pend[0] = '0;
    iv_wr[0] = '0;
    for (int i = 1; i < 8; i++) check("rr_period", 64'(gq[i] - gq[i-1]), 64'd2);
    tick();
    tick();
    tick();

    // Downstream withholds ack for 20 cycles while another source waits.
    dx = 46'h2AAA_1111_0001;
    dy = 46'h1555_2222_0003;
    hold[0] = 20;
    set_src(0, 1, dx);
    push(0, 1, dx);
    tgt = n_grant[0] + 1;
    for (int i = 0; i < 10 && n_grant[0] < tgt; i++) tick();
    check("hold_grant_count", 64'(n_grant[0]), 64'(tgt));
    set_src(0, 3, dy);
    push(0, 3, dy);
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!(o_wr[0] === 1'b1 && ov_desc[0] === dx && ov_ack[0] === 4'b0)) stable = 1'b0;
    end
    check("hold_stable", 64'(stable), 64'd1);
    tgt = n_grant[0] + 1;
    for (int i = 0; i < 10 && n_grant[0] < tgt; i++) tick();
    check("hold_next_grant", 64'(n_grant[0]), 64'(tgt));
    check("hold_next_gap", 64'(gap_obs[0]), 64'd1);
    tick();
    tick();

    // Spurious downstream ack while idle.
    spurious[0] = 1'b1;
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (!(o_wr[0] === 1'b0 && ov_ack[0] === 4'b0 && ov_desc[0] === 46'b0)) stable = 1'b0;
    end
    spurious[0] = 1'b0;
    tick();
    check("spurious_quiet", 64'(stable), 64'd1);

    // Move pointer to 1, then grant 2 and reset mid-transfer with 0 and 3 pending.
    start = cyc;
    set_src(0, 1, make_desc(1, 9));
    push(0, 1, make_desc(1, 9));
    tgt = n_grant[0] + 1;
    for (int i = 0; i < 10 && n_grant[0] < tgt; i++) tick();
    check("pre_rst_grant_cyc", 64'(grant_cyc[0]), 64'(start + 1));
    tick();
    tick();
    ds_en[0] = 1'b0;
    set_src(0, 0, make_desc(0, 7));
    set_src(0, 2, make_desc(2, 7));
    push(0, 2, make_desc(2, 7));
    tgt = n_grant[0] + 1;
    for (int i = 0; i < 10 && n_grant[0] < tgt; i++) tick();
    check("send_grant_count", 64'(n_grant[0]), 64'(tgt));
    tick();
    tick();
    check("send_wr_held", 64'(o_wr[0]), 64'd1);
    set_src(0, 3, make_desc(3, 7));
    #3;
    rst = 1'b1;
    #1;
    check("rst_async_wr", 64'(o_wr[0]), 64'd0);
    check("rst_async_desc", 64'(ov_desc[0]), 64'd0);
    check("rst_async_ack", 64'(ov_ack[0]), 64'd0);
    tick();
    rst = 1'b0;
    rel = cyc;
    ds_en[0] = 1'b1;
    base = gq.size();
    push(0, 0, make_desc(0, 7));
    push(0, 3, make_desc(3, 7));
    tgt = n_grant[0] + 2;
    for (int i = 0; i < 20 && n_grant[0] < tgt; i++) tick();
    check("rst_regrant_count", 64'(n_grant[0]), 64'(tgt));
    check("rst_first_grant_cyc", 64'(gq[base]), 64'(rel + 1));
    tick();
    tick();

    // Gap instance: sources 1 and 3 requesting, gap of 3 cycles.
    set_src(1, 1, make_desc(1, 3));
    set_src(1, 3, make_desc(3, 3));
    push(1, 1, make_desc(1, 3));
    push(1, 3, make_desc(3, 3));
    tgt = n_grant[1] + 2;
    for (int i = 0; i < 30 && n_grant[1] < tgt; i++) tick();
    check("gap_grant_count", 64'(n_grant[1]), 64'(tgt));
    check("gap_ack_to_grant", 64'(gap_obs[1]), 64'd4);
    for (int i = 0; i < 4; i++) tick();

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
